// File: rtl/translator_pkg.sv
// Shared types for the address-translation tile: page numbers and the TLB port arbiter state.
package translator_pkg;

  localparam int DCP_PADDR = 40;
  localparam int PN_BITS   = DCP_PADDR - 12;

  typedef logic [PN_BITS-1:0] pn_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } arb_state_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tlb_port_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or above rr_ptr, wrapping modulo N.
// Purely combinational, no state; the caller owns the pointer.
module tlb_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             any_valid,
  output logic [IDX_W-1:0] winner
);

  int               pos;
  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest set bit to rr_ptr is written last.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    pos       = 0;
    cand      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = int'(rr_ptr) + i;
      if (pos >= N) pos = pos - N;
      cand = IDX_W'(pos);
      if (req[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

endmodule

// File: rtl/tlb_port_arbiter.sv
// Round-robin share of one TLB lookup port among NUM_REQ translators; one lookup outstanding.
// Grant registered in IDLE, tlb_valid next cycle; response routed back in the TLB ack cycle; TLB may stall indefinitely.
module tlb_port_arbiter
  import translator_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PN_W    = PN_BITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*PN_W-1:0] req_vpn,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [PN_W-1:0]         req_ppn,
  output logic                    tlb_valid,
  output logic [PN_W-1:0]         tlb_vpn,
  input  logic                    tlb_ack,
  input  logic [PN_W-1:0]         tlb_ppn,
  output logic                    busy
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] grant_idx_q;
  logic [PN_W-1:0]  vpn_q;

  logic             any_valid;
  logic [IDX_W-1:0] winner;
  logic [PN_W-1:0]  win_vpn;
  logic [IDX_W-1:0] rr_next;
  logic             grant_load;
  logic             lookup_done;

  tlb_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .any_valid (any_valid),
    .winner    (winner)
  );

  assign win_vpn = req_vpn[int'(winner)*PN_W +: PN_W];
  assign rr_next = (int'(grant_idx_q) == NUM_REQ - 1) ? '0 : grant_idx_q + IDX_W'(1);
  assign tlb_vpn = vpn_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    tlb_valid   = 1'b0;
    busy        = 1'b0;
    req_ack     = '0;
    req_ppn     = '0;
    grant_load  = 1'b0;
    lookup_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          grant_load = 1'b1;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        tlb_valid = 1'b1;
        busy      = 1'b1;
        if (tlb_ack) begin
          // A requester that withdrew still lets the lookup finish, but gets no ack or data.
          req_ack[grant_idx_q] = req_valid[grant_idx_q];
          if (req_valid[grant_idx_q]) req_ppn = tlb_ppn;
          lookup_done = 1'b1;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      vpn_q       <= '0;
    end else begin
      if (grant_load) begin
        grant_idx_q <= winner;
        vpn_q       <= win_vpn;
      end
      if (lookup_done) rr_ptr_q <= rr_next;
    end
  end

`ifndef SYNTHESIS
  a_ack_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ack));

  a_tlb_hold: assert property (@(posedge clk) disable iff (!rst_n)
    tlb_valid && !tlb_ack |=> tlb_valid && $stable(tlb_vpn));

  // Waiting requesters must hold; the granted one may withdraw and is absorbed by ack gating.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_hold
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
      req_valid[g] && !req_ack[g] && !(busy && grant_idx_q == IDX_W'(g)) |=> req_valid[g]);
  end
`endif

endmodule

// File: doc/tlb_port_arbiter.md
Name: tlb_port_arbiter

Overview:
- Shares one TLB lookup port between NUM_REQ translator units. Each translator unit converts a VPN-bearing memory request into a PPN-bearing one.
- Sits between the translator units' tlb_if master ports and the single TLB slave.
- Arbitration is round-robin, with one lookup outstanding at a time. The granted VPN is latched, and the TLB response is routed back to the owning requester in the same cycle as the TLB ack.

Parameters:
- NUM_REQ, 4, number of requesting translator units (2..8).
- PN_W, 28, page-number width, equal to DCP_PADDR-12 (matches translator_pkg::pn_t).
- IDX_W, $clog2(NUM_REQ), grant index width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- req_valid  in  NUM_REQ  per-requester lookup request; held high until the matching req_ack.
- req_vpn  in  NUM_REQ*PN_W  per-requester VPN; slice i is req_vpn[i*PN_W +: PN_W].
- req_ack  out  NUM_REQ  one-hot, single-cycle completion pulse to the granted requester.
- req_ppn  out  PN_W  translated PPN; valid only in the cycle where a req_ack bit is high; broadcast to all requesters.
- tlb_valid  out  1  lookup request to the TLB.
- tlb_vpn  out  PN_W  latched VPN of the granted requester.
- tlb_ack  in  1  TLB completion; meaningful only while tlb_valid=1.
- tlb_ppn  in  PN_W  TLB result, qualified by tlb_ack.
- busy  out  1  a lookup is outstanding (state==S_BUSY).

Behaviour:
- Reset: rst_n is synchronous and active-low; clk is the clock.
- Reset values: state=S_IDLE, rr_ptr=0, grant_idx=0, vpn_q=0. Outputs: tlb_valid=0, tlb_vpn=0, req_ack=0, req_ppn=0 (driven from tlb_ppn only when acked, else 0), busy=0.
- S_IDLE:
  - If any req_valid is set, select the winner: the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register grant_idx=winner and vpn_q=req_vpn[winner], then go to S_BUSY.
  - No tlb_valid in this cycle.
- S_BUSY:
  - tlb_valid=1 and tlb_vpn=vpn_q.
  - tlb_valid stays high every cycle until tlb_ack; the TLB may take any number of cycles.
  - On tlb_ack=1 (same cycle, combinational):
    - req_ack[grant_idx]=req_valid[grant_idx].
    - req_ppn=tlb_ppn.
    - Next: rr_ptr=(grant_idx+1) mod NUM_REQ, state=S_IDLE.
- Latency:
  - The request is seen in S_IDLE at cycle t; tlb_valid goes high at t+1.
  - Earliest req_ack is at t+1 if the TLB acks combinationally.
  - Back-to-back lookups are separated by one idle cycle (S_IDLE re-arbitrates). Throughput is one lookup per 2 cycles minimum.
- Fairness: a requester that is continuously valid is granted within NUM_REQ lookups.
- Arbitration sampling: only S_IDLE samples req_valid. Requests arriving during S_BUSY wait.
- Requester drops valid while granted (protocol violation): the TLB transaction still completes and is not aborted, since tlb_valid must not drop before ack. req_ack is suppressed (gated by req_valid) and the result is discarded. rr_ptr still advances.
- tlb_ack while S_IDLE: ignored, no req_ack.
- vpn_q is latched once at grant. Later changes on req_vpn do not affect tlb_vpn.
- Reset mid-lookup: next cycle tlb_valid=0 and state=S_IDLE; the pending TLB response is dropped.
- NUM_REQ=1 degenerates to a registered pass-through with the same timing.
- Assertions (non-synthesis):
  - req_ack is onehot0.
  - tlb_valid && !tlb_ack |=> tlb_valid && $stable(tlb_vpn).
  - A requester's req_valid high without ack |=> it stays high.

Decomposition:
- translator_pkg: reuse pn_t; add arb_state_t enum {S_IDLE, S_BUSY}.
- One sub-module, tlb_rr_pick: purely combinational rotate-priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: any_valid, winner index.
  - Reusable by other shared-resource arbiters in the tile.
- Top level holds the FSM and the grant/VPN/pointer registers.

Test Plan:
- Single request: req_valid=4'b0001, vpn=0x1234, TLB acks 3 cycles after tlb_valid with ppn=0xABCD. Expect tlb_valid from t+1 to t+4, tlb_vpn=0x1234, req_ack=4'b0001 at t+4 with req_ppn=0xABCD, then rr_ptr=1.
- All four requesting continuously, TLB acks immediately. Expect grants in order 0,1,2,3,0, with req_ack pulses every 2 cycles and each requester receiving its own ppn (ppn=vpn+0x100).
- Requester 2 raises valid while requester 0 is in S_BUSY. Expect no change to tlb_vpn; requester 2 is granted in the next S_IDLE after ack0.
- Requester 1 granted, then drops req_valid before tlb_ack. Expect tlb_valid held until ack, req_ack=0, next grant goes to requester 2 (if valid).
- rst_n asserted for 1 cycle while S_BUSY with TLB stalled. Expect tlb_valid=0 and busy=0 the next cycle, no req_ack, and the following arbitration starting from rr_ptr=0.
- Integration: two translator units in front of the arbiter, issuing concurrent loads with VPNs 0x00010 and 0x00020, TLB map vpn→vpn+0x7000. Expect output addresses {0x07010,offset} and {0x07020,offset}, with no lost or duplicated requests.
